// File: rtl/gb_instr_driver.sv
// Program-buffer sequencer that plays {instruction, data} beats into the gbprocessor and
// snapshots its register probe after each beat. Define GB_DRIVER_LOOP_EN to add loop_i.
module gb_instr_driver #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [7:0]    prog_instr_i,
    input  logic [7:0]    prog_data_i,
    input  logic          start_i,
    input  logic [AW:0]   length_i,
    input  logic          pause_i,
`ifdef GB_DRIVER_LOOP_EN
    input  logic          loop_i,
`endif
    input  logic [63:0]   probe_i,
    output logic [7:0]    instruction_o,
    output logic [7:0]    data_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW:0]   issue_count_o,
    output logic [63:0]   probe_snapshot_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [15:0]  prog_mem_q [DEPTH];

    state_t       state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]  len_q, len_d;
    logic [7:0]   instr_q, instr_d;
    logic [7:0]   data_q, data_d;
    logic         valid_q, valid_d;
    logic         valid_dly_q;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [AW:0]  count_q, count_d;
    logic         drain_q, drain_d;
    logic [63:0]  snap_q;

    logic [AW:0]  len_clamped;
    logic         last_beat;

    assign len_clamped = (length_i > DEPTH_L) ? DEPTH_L : length_i;
    assign last_beat   = ({1'b0, ptr_q} == (len_q - 1'b1));

    // Buffer is not reset; writes only land while idle.
    always_ff @(posedge clock_i) begin
        if (prog_we_i && state_q == IDLE) begin
            prog_mem_q[prog_addr_i] <= {prog_instr_i, prog_data_i};
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        instr_d = instr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_clamped;
                    ptr_d   = '0;
                    count_d = '0;
                    if (len_clamped != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                if (!pause_i) begin
                    instr_d = prog_mem_q[ptr_q][15:8];
                    data_d  = prog_mem_q[ptr_q][7:0];
                    valid_d = 1'b1;
                    if (count_q != '1) begin
                        count_d = count_q + 1'b1;
                    end
                    if (last_beat) begin
`ifdef GB_DRIVER_LOOP_EN
                        if (loop_i) begin
                            ptr_d = '0;
                        end else begin
                            state_d = DRAIN;
                            drain_d = 1'b0;
                        end
`else
                        state_d = DRAIN;
                        drain_d = 1'b0;
`endif
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Two quiet cycles let the last beat's snapshot land before done.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            len_q       <= '0;
            instr_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            valid_dly_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            drain_q     <= 1'b0;
            snap_q      <= 64'h0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            valid_dly_q <= valid_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            if (valid_dly_q) begin
                snap_q <= probe_i;
            end
        end
    end

    assign instruction_o    = instr_q;
    assign data_o           = data_q;
    assign valid_o          = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign issue_count_o    = count_q;
    assign probe_snapshot_o = snap_q;

endmodule

// File: tb/tb_gb_instr_driver.sv
// Randomized bench for gb_instr_driver: a tiny A/B processor model drives the probe and a
// program-level reference predicts beats, done timing, counts and snapshots.
module tb_gb_instr_driver;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_instr;
    logic [7:0]    prog_data;
    logic          start;
    logic [AW:0]   length;
    logic          pause;
`ifdef GB_DRIVER_LOOP_EN
    logic          loop_en;
`endif
    logic [63:0]   probe;
    logic [7:0]    instruction_o;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          busy_o;
    logic          done_o;
    logic [AW:0]   issue_count_o;
    logic [63:0]   probe_snapshot_o;

    logic [7:0]    cpu_a, cpu_b;
    logic [47:0]   probe_lo;
    logic [15:0]   ref_mem [DEPTH];
    logic [63:0]   snap_exp;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    gb_instr_driver #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock_i          (clk),
        .reset_i          (rst_n),
        .prog_we_i        (prog_we),
        .prog_addr_i      (prog_addr),
        .prog_instr_i     (prog_instr),
        .prog_data_i      (prog_data),
        .start_i          (start),
        .length_i         (length),
        .pause_i          (pause),
`ifdef GB_DRIVER_LOOP_EN
        .loop_i           (loop_en),
`endif
        .probe_i          (probe),
        .instruction_o    (instruction_o),
        .data_o           (data_o),
        .valid_o          (valid_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .issue_count_o    (issue_count_o),
        .probe_snapshot_o (probe_snapshot_o)
    );

    // Minimal processor: LD B,d8 / LD A,d8 / LD A,B / ADD A,B on each valid beat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_a <= 8'h00;
            cpu_b <= 8'h00;
        end else if (valid_o) begin
            case (instruction_o)
                8'h06:   cpu_b <= data_o;
                8'h3E:   cpu_a <= data_o;
                8'h78:   cpu_a <= cpu_b;
                8'h80:   cpu_a <= cpu_a + cpu_b;
                default: ;
            endcase
        end
    end

    assign probe = {cpu_a, cpu_b, probe_lo};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic write_entry(input int a, input logic [7:0] ins, input logic [7:0] dat);
        prog_we    = 1'b1;
        prog_addr  = a[AW-1:0];
        prog_instr = ins;
        prog_data  = dat;
        ref_mem[a] = {ins, dat};
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Edge 0 samples start; sample i is taken on the negedge after edge i.
    task automatic run_prog(input int len, input int p_from, input int p_cnt, input int pause_pct,
                            input bit wr_at_start, input bit poke, input int loop_beats);
        int          eff, total, beats, first_t, last_t, done_cnt, done_at, wa;
        logic [63:0] pe[$];
        bit          vs[$];
        logic [7:0]  last_i;
        eff   = (len > DEPTH) ? DEPTH : len;
        total = 0;
        if (eff > 0) begin
            do total += eff; while (total <= loop_beats);
        end
        beats = 0; first_t = -1; last_t = -1; done_cnt = 0; done_at = -1; last_i = 8'h00;
        start  = 1'b1;
        length = len[AW:0];
        pause  = 1'b0;
        if (wr_at_start) begin
            wa         = int'($urandom_range(DEPTH - 1));
            prog_we    = 1'b1;
            prog_addr  = wa[AW-1:0];
            prog_instr = 8'($urandom);
            prog_data  = 8'($urandom);
            ref_mem[wa] = {prog_instr, prog_data};
        end
`ifdef GB_DRIVER_LOOP_EN
        loop_en = (loop_beats > 0);
`endif
        probe_lo = 48'({$urandom, $urandom});
        pe.push_back({cpu_a, cpu_b, probe_lo});
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            vs.push_back(valid_o);
            if (i >= 2 && vs[i-2]) snap_exp = pe[i];
            check("snapshot", probe_snapshot_o, snap_exp);
            if (valid_o) begin
                if (beats < total && eff > 0) begin
                    check("beat_instr", 64'(instruction_o), 64'(ref_mem[beats % eff][15:8]));
                    check("beat_data", 64'(data_o), 64'(ref_mem[beats % eff][7:0]));
                    last_i = ref_mem[beats % eff][15:8];
                end
                if (first_t < 0) first_t = i;
                last_t = i;
                beats++;
            end else if (beats > 0 && beats <= total) begin
                check("hold_instr", 64'(instruction_o), 64'(last_i));
            end
            if (done_o) begin
                done_cnt++;
                done_at = i;
            end
            check("busy", 64'(busy_o), 64'((eff > 0) && (done_at < 0)));
            if (done_at >= 0 && i >= done_at + 2) break;
            start   = poke && (i == 1);
            prog_we = poke && (i == 1);
            if (poke && i == 1) begin
                prog_addr  = '0;
                prog_instr = 8'h3E;
                prog_data  = 8'($urandom);
            end
            pause = ((i + 1) >= p_from && (i + 1) < p_from + p_cnt) ||
                    (pause_pct > 0 && int'($urandom_range(99)) < pause_pct);
`ifdef GB_DRIVER_LOOP_EN
            loop_en = (beats + 1 <= loop_beats);
`endif
            probe_lo = 48'({$urandom, $urandom});
            pe.push_back({cpu_a, cpu_b, probe_lo});
        end
        start   = 1'b0;
        prog_we = 1'b0;
        pause   = 1'b0;
        check("beat_count", 64'(beats), 64'(total));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("done_timing", 64'(done_at), 64'((total > 0) ? last_t + 3 : 1));
        if (pause_pct == 0 && (p_cnt == 0 || p_from > 1) && total > 0)
            check("first_beat", 64'(first_t), 64'(1));
        check("issue_count", 64'(issue_count_o), 64'((total > 31) ? 31 : total));
        $display("run len=%0d beats=%0d expected=%0d done_at=%0d", len, beats, total, done_at);
    endtask

    task automatic reset_mid_run();
        int beats, dn, vcnt;
        beats = 0; dn = 0; vcnt = 0;
        start  = 1'b1;
        length = 5'd8;
        pause  = 1'b0;
        for (int i = 0; i < 20 && beats < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid_o) beats++;
        end
        check("rst_reach_beat3", 64'(beats), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_instr", 64'(instruction_o), 64'(0));
        check("rst_count", 64'(issue_count_o), 64'(0));
        check("rst_snapshot", probe_snapshot_o, 64'h0);
        snap_exp = 64'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o) dn++;
            if (valid_o) vcnt++;
        end
        check("rst_no_done", 64'(dn), 64'(0));
        check("rst_no_valid", 64'(vcnt), 64'(0));
        $display("reset mid-run after %0d beats", beats);
    endtask

    initial begin
        int len;
        rst_n = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_instr = 8'h00; prog_data = 8'h00;
        start = 1'b0; length = '0; pause = 1'b0; probe_lo = 48'h0;
`ifdef GB_DRIVER_LOOP_EN
        loop_en = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #1;
        check("reset_instr", 64'(instruction_o), 64'(0));
        check("reset_data", 64'(data_o), 64'(0));
        check("reset_valid", 64'(valid_o), 64'(0));
        check("reset_busy", 64'(busy_o), 64'(0));
        check("reset_done", 64'(done_o), 64'(0));
        check("reset_count", 64'(issue_count_o), 64'(0));
        check("reset_snapshot", probe_snapshot_o, 64'h0);
        snap_exp = 64'h0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) write_entry(a, 8'($urandom), 8'($urandom));
        write_entry(0, 8'h06, 8'hAA);
        write_entry(1, 8'h78, 8'h00);
        write_entry(2, 8'h80, 8'h00);

        run_prog(3, 0, 0, 0, 1'b0, 1'b0, 0);
        check("basic_A", 64'(probe_snapshot_o[63:56]), 64'(8'h54));
        check("basic_B", 64'(probe_snapshot_o[55:48]), 64'(8'hAA));

        run_prog(3, 2, 2, 0, 1'b0, 1'b0, 0);
        check("pause_A", 64'(probe_snapshot_o[63:56]), 64'(8'h54));

        run_prog(0, 0, 0, 0, 1'b0, 1'b0, 0);
        run_prog(20, 0, 0, 0, 1'b0, 1'b0, 0);
        run_prog(5, 0, 0, 0, 1'b0, 1'b1, 0);
        run_prog(3, 0, 0, 0, 1'b0, 1'b0, 0);

`ifdef GB_DRIVER_LOOP_EN
        run_prog(2, 0, 0, 0, 1'b0, 1'b0, 5);
`endif

        for (int r = 0; r < 12; r++) begin
            repeat (int'($urandom_range(3))) write_entry(int'($urandom_range(DEPTH - 1)),
                                                         8'($urandom), 8'($urandom));
            len = int'($urandom_range(20));
            run_prog(len, int'($urandom_range(1, 6)), int'($urandom_range(3)),
                     int'($urandom_range(30)), 1'($urandom_range(1)),
                     (len > 0) && 1'($urandom_range(1)), 0);
        end

        reset_mid_run();
        run_prog(int'($urandom_range(1, 16)), 0, 0, 0, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
